// File: rtl/z80_bus_sequencer_pkg.sv
// Shared types for the Z80 bus sequencer: FSM state encoding, bus-cycle codes and a
// counter sizing helper.
package z80_bus_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIXED   = 2'd1,
    ACKWAIT = 2'd2,
    DONE    = 2'd3
  } seq_state_e;

  // Bus-cycle type codes; also the bit index of each qualifier in the decode vector.
  typedef enum logic [2:0] {
    CycMr = 3'd0,
    CycOf = 3'd1,
    CycMw = 3'd2,
    CycIr = 3'd3,
    CycIw = 3'd4,
    CycIa = 3'd5
  } cycle_e;

  localparam int unsigned NumQual = 6;

  // The tick counter serves both the fixed wait and the ack timeout.
  function automatic int unsigned cnt_width(input int unsigned ack_timeout,
                                            input int unsigned io_wait);
    int unsigned m;
    m = (ack_timeout > io_wait) ? ack_timeout : io_wait;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/z80_edge_pulse.sv
// Registered rising-edge detector: 'rise' is the combinational edge, 'pulse' its
// one-clock registered copy.
module z80_edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise,
  output logic pulse
);

  logic prev_q;

  assign rise = level & ~prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      prev_q <= level;
      pulse  <= rise;
    end
  end

endmodule

// File: rtl/z80_bus_sequencer.sv
// Turns Z80 bus controls into one-clock access strobes with latched address/data and
// stretches I/O cycles through wait_n (fixed ticks or ack handshake with timeout).
module z80_bus_sequencer
  import z80_bus_sequencer_pkg::*;
#(
  parameter int unsigned IO_WAIT_TICKS = 0,
  parameter int unsigned ACK_TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_enable,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  input  logic [15:0] A,
  input  logic [7:0]  dout,
  input  logic        io_slow,
  input  logic        io_ack,
  output logic        wait_n,
  output logic        mem_rd_stb,
  output logic        opfetch_stb,
  output logic        mem_wr_stb,
  output logic        io_rd_stb,
  output logic        io_wr_stb,
  output logic        inta_stb,
  output logic [15:0] addr_q,
  output logic [7:0]  wdata_q,
  output logic        timeout_stb
);

  localparam int unsigned CntW = cnt_width(ACK_TIMEOUT, IO_WAIT_TICKS);

  logic [NumQual-1:0] qual;
  logic [NumQual-1:0] rise;
  logic [NumQual-1:0] pulse;
  seq_state_e         state_q;
  logic [CntW-1:0]    cnt_q;
  logic [CntW-1:0]    cnt_inc;
  logic               io_start;

  assign qual[CycMr] = ~mreq_n & ~rd_n & rfsh_n;
  assign qual[CycOf] = qual[CycMr] & ~m1_n;
  assign qual[CycMw] = ~mreq_n & ~wr_n;
  assign qual[CycIr] = ~iorq_n & ~rd_n & m1_n;
  assign qual[CycIw] = ~iorq_n & ~wr_n;
  assign qual[CycIa] = ~iorq_n & ~m1_n;

  for (genvar i = 0; i < NumQual; i++) begin : g_edge
    z80_edge_pulse u_edge (
      .clk  (clk),
      .rst  (rst),
      .level(qual[i]),
      .rise (rise[i]),
      .pulse(pulse[i])
    );
  end

  assign mem_rd_stb  = pulse[CycMr];
  assign opfetch_stb = pulse[CycOf];
  assign mem_wr_stb  = pulse[CycMw];
  assign io_rd_stb   = pulse[CycIr];
  assign io_wr_stb   = pulse[CycIw];
  assign inta_stb    = pulse[CycIa];

  // Saturating increment so a long stall can never wrap back below the limit.
  assign cnt_inc  = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + CntW'(1);
  assign io_start = rise[CycIr] | rise[CycIw];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wait_n      <= 1'b1;
      timeout_stb <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      timeout_stb <= 1'b0;
      if (|rise) addr_q <= A;
      if (rise[CycMw] | rise[CycIw]) wdata_q <= dout;

      unique case (state_q)
        IDLE: begin
          if (io_start) begin
            cnt_q <= '0;
            if (io_slow && !io_ack) begin
              state_q <= ACKWAIT;
              wait_n  <= 1'b0;
            end else if (!io_slow && (IO_WAIT_TICKS > 0)) begin
              state_q <= FIXED;
              wait_n  <= 1'b0;
            end else begin
              state_q <= DONE;
            end
          end
        end
        FIXED: begin
          if (clk_enable) begin
            cnt_q <= cnt_inc;
            if (cnt_inc >= CntW'(IO_WAIT_TICKS)) begin
              wait_n  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        ACKWAIT: begin
          // An ack arriving on the expiry tick takes precedence over the timeout.
          if (io_ack) begin
            wait_n  <= 1'b1;
            state_q <= DONE;
          end else if (clk_enable) begin
            cnt_q <= cnt_inc;
            if (cnt_inc >= CntW'(ACK_TIMEOUT)) begin
              wait_n      <= 1'b1;
              timeout_stb <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          if (iorq_n) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_bus_sequencer.sv
// Directed bench for z80_bus_sequencer: a cycle-level behavioural model checked every
// clock, plus hand-computed expectations for each scenario.
module tb_z80_bus_sequencer;

  localparam int unsigned IoWait = 2;
  localparam int unsigned AckTo  = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_enable = 1'b0;
  logic        m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic        rfsh_n = 1'b1;
  logic [15:0] A = 16'h0;
  logic [7:0]  dout = 8'h0;
  logic        io_slow = 1'b0, io_ack = 1'b0;
  logic        wait_n, mem_rd_stb, opfetch_stb, mem_wr_stb, io_rd_stb, io_wr_stb, inta_stb;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        timeout_stb;

  z80_bus_sequencer #(
    .IO_WAIT_TICKS(IoWait),
    .ACK_TIMEOUT  (AckTo)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_enable (clk_enable),
    .m1_n       (m1_n),
    .mreq_n     (mreq_n),
    .iorq_n     (iorq_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .rfsh_n     (rfsh_n),
    .A          (A),
    .dout       (dout),
    .io_slow    (io_slow),
    .io_ack     (io_ack),
    .wait_n     (wait_n),
    .mem_rd_stb (mem_rd_stb),
    .opfetch_stb(opfetch_stb),
    .mem_wr_stb (mem_wr_stb),
    .io_rd_stb  (io_rd_stb),
    .io_wr_stb  (io_wr_stb),
    .inta_stb   (inta_stb),
    .addr_q     (addr_q),
    .wdata_q    (wdata_q),
    .timeout_stb(timeout_stb)
  );

  always #5 clk = ~clk;

  // T-state enable toggles shortly after each rising edge: one tick every two clocks.
  initial forever begin
    @(posedge clk);
    #2 clk_enable = ~clk_enable;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Behavioural model: bit order mem_rd, opfetch, mem_wr, io_rd, io_wr, inta.
  logic [5:0]  m_prev, q, r, exp_stb;
  logic [15:0] exp_addr;
  logic [7:0]  exp_wdata;
  logic        exp_wait, exp_tmo;
  bit          busy, ack_mode;
  int          left;

  always @(posedge clk) begin
    q[0] = !mreq_n && !rd_n && rfsh_n;
    q[1] = q[0] && !m1_n;
    q[2] = !mreq_n && !wr_n;
    q[3] = !iorq_n && !rd_n && m1_n;
    q[4] = !iorq_n && !wr_n;
    q[5] = !iorq_n && !m1_n;
    if (rst) begin
      m_prev = '0; exp_stb = '0; exp_addr = '0; exp_wdata = '0;
      exp_wait = 1'b1; exp_tmo = 1'b0; busy = 0; ack_mode = 0; left = 0;
    end else begin
      r = q & ~m_prev;
      m_prev = q;
      exp_stb = r;
      exp_tmo = 1'b0;
      if (r != 0) exp_addr = A;
      if (r[2] || r[4]) exp_wdata = dout;
      if (!busy && (r[3] || r[4])) begin
        busy = 1;
        ack_mode = io_slow;
        if (io_slow && !io_ack) begin
          left = AckTo; exp_wait = 1'b0;
        end else if (!io_slow && IoWait > 0) begin
          left = IoWait; exp_wait = 1'b0;
        end
      end else if (busy && !exp_wait) begin
        if (ack_mode && io_ack) exp_wait = 1'b1;
        else if (clk_enable) begin
          left--;
          if (left == 0) begin
            exp_wait = 1'b1;
            exp_tmo = ack_mode;
          end
        end
      end else if (busy && iorq_n) begin
        busy = 0;
      end
    end
  end

  // Running totals used by the directed checks.
  int low_ticks = 0;
  int tmo_total = 0;
  always @(posedge clk) begin
    if (!rst && !wait_n && clk_enable) low_ticks++;
    if (timeout_stb) tmo_total++;
  end

  always @(negedge clk) begin
    check("m_mem_rd",  mem_rd_stb,  exp_stb[0]);
    check("m_opfetch", opfetch_stb, exp_stb[1]);
    check("m_mem_wr",  mem_wr_stb,  exp_stb[2]);
    check("m_io_rd",   io_rd_stb,   exp_stb[3]);
    check("m_io_wr",   io_wr_stb,   exp_stb[4]);
    check("m_inta",    inta_stb,    exp_stb[5]);
    check("m_addr",    addr_q,      exp_addr);
    check("m_wdata",   wdata_q,     exp_wdata);
    check("m_wait_n",  wait_n,      exp_wait);
    check("m_timeout", timeout_stb, exp_tmo);
  end

  task automatic wait_release(input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (wait_n) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic release_bus();
    m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
  endtask

  function automatic logic [6:0] all_stb();
    return {mem_rd_stb, opfetch_stb, mem_wr_stb, io_rd_stb, io_wr_stb, inta_stb, timeout_stb};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int t0, k0;

    repeat (3) @(negedge clk);
    check("rst_wait_n", wait_n, 1);
    check("rst_addr", addr_q, 0);
    check("rst_wdata", wdata_q, 0);
    check("rst_strobes", all_stb(), 0);
    rst = 1'b0;
    @(negedge clk);

    // Opfetch at 0038
    A = 16'h0038; m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    check("of_opfetch", opfetch_stb, 1);
    check("of_mem_rd", mem_rd_stb, 1);
    check("of_addr", addr_q, 16'h0038);
    check("of_wait_n", wait_n, 1);
    @(negedge clk);
    check("of_single", opfetch_stb, 0);
    release_bus();
    @(negedge clk);
    A = 16'h0012; mreq_n = 1'b0; rfsh_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rfsh1_none", all_stb(), 0);
    end
    release_bus();
    @(negedge clk);

    // Memory write A5 -> 4000, then refresh
    A = 16'h4000; dout = 8'hA5; mreq_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    check("mw_stb", mem_wr_stb, 1);
    check("mw_wdata", wdata_q, 8'hA5);
    @(negedge clk);
    check("mw_single", mem_wr_stb, 0);
    release_bus();
    @(negedge clk);
    A = 16'h0013; mreq_n = 1'b0; rfsh_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rfsh2_none", all_stb(), 0);
    end
    check("rfsh2_addr_hold", addr_q, 16'h4000);
    release_bus();
    @(negedge clk);

    // Fast OUT 07 -> 00FE with two fixed wait ticks
    t0 = low_ticks;
    A = 16'h00FE; dout = 8'h07; iorq_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    check("out_stb", io_wr_stb, 1);
    check("out_wait_low", wait_n, 0);
    wait_release(20, ok);
    check("out_released", ok, 1);
    check("out_ticks", low_ticks - t0, 2);
    check("out_wdata", wdata_q, 8'h07);
    release_bus();
    repeat (2) @(negedge clk);

    // Slow IN from FFFD, ack after 3 ticks
    t0 = low_ticks; k0 = tmo_total;
    A = 16'hFFFD; io_slow = 1'b1; iorq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    check("in_stb", io_rd_stb, 1);
    check("in_wait_low", wait_n, 0);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (low_ticks - t0 >= 3) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check("in_3_ticks", ok, 1);
    check("in_still_low", wait_n, 0);
    io_ack = 1'b1;
    @(negedge clk);
    check("in_ack_release", wait_n, 1);
    release_bus(); io_ack = 1'b0; io_slow = 1'b0;
    repeat (2) @(negedge clk);
    check("in_no_timeout", tmo_total - k0, 0);

    // Slow IN, ack never comes
    t0 = low_ticks; k0 = tmo_total;
    A = 16'hFFFD; io_slow = 1'b1; iorq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    wait_release(60, ok);
    check("to_released", ok, 1);
    check("to_ticks", low_ticks - t0, 15);
    check("to_pulse_now", timeout_stb, 1);
    @(negedge clk);
    check("to_single", tmo_total - k0, 1);
    release_bus(); io_slow = 1'b0;
    repeat (2) @(negedge clk);

    // Ack on the same clock as the 15th tick
    t0 = low_ticks; k0 = tmo_total;
    A = 16'hFFFD; io_slow = 1'b1; iorq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (low_ticks - t0 == 14 && clk_enable) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check("race_reached", ok, 1);
    io_ack = 1'b1;
    @(negedge clk);
    check("race_wait_n", wait_n, 1);
    check("race_no_tmo", timeout_stb, 0);
    @(negedge clk);
    check("race_tmo_count", tmo_total - k0, 0);
    release_bus(); io_ack = 1'b0; io_slow = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while in ACKWAIT
    A = 16'hFFFD; io_slow = 1'b1; iorq_n = 1'b0; rd_n = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_low", wait_n, 0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_wait_n", wait_n, 1);
    check("mid_rst_strobes", all_stb(), 0);
    release_bus(); io_slow = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Next I/O cycle handled normally (fast IN, fixed waits)
    t0 = low_ticks;
    A = 16'h00FE; iorq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    check("post_rst_in_stb", io_rd_stb, 1);
    check("post_rst_addr", addr_q, 16'h00FE);
    wait_release(20, ok);
    check("post_rst_released", ok, 1);
    check("post_rst_ticks", low_ticks - t0, 2);
    release_bus();
    repeat (2) @(negedge clk);

    // Interrupt acknowledge
    A = 16'h00FF; m1_n = 1'b0; iorq_n = 1'b0;
    @(negedge clk);
    check("inta_stb", inta_stb, 1);
    check("inta_only", all_stb(), 7'b0000010);
    check("inta_wait_n", wait_n, 1);
    @(negedge clk);
    check("inta_no_wait", wait_n, 1);
    release_bus();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/z80_bus_sequencer.md
Name: z80_bus_sequencer

Overview:
- Sits directly downstream of the Z80 CPU core wrapper, on the same clock.
- Consumes the CPU bus control outputs, address and data-out.
- Produces single-clock access strobes with latched address/data for memory, I/O, opcode fetch and interrupt acknowledge.
- Closes the loop upstream by driving the CPU wait_n input, stretching I/O cycles for slow peripherals through a ready/ack handshake with timeout.

Parameters:
- IO_WAIT_TICKS, 0: extra wait T-states (clk_enable ticks) inserted on every I/O cycle whose device does not request a handshake; range 0..15.
- ACK_TIMEOUT, 15: maximum clk_enable ticks wait_n is held low waiting for io_ack; range 1..255.

Ports:
- clk  in  1  system clock, same clock as the CPU.
- rst  in  1  synchronous reset, active-high.
- clk_enable  in  1  CPU T-state enable; the same signal the CPU receives.
- m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n  in  1 each  CPU bus controls, active-low.
- A  in  16  CPU address bus.
- dout  in  8  CPU data out.
- io_slow  in  1  decoder flag: the current I/O address needs the ack handshake.
- io_ack  in  1  peripheral ready, level; sampled on clk.
- wait_n  out  1  registered; to CPU WAIT_n.
- mem_rd_stb, opfetch_stb, mem_wr_stb, io_rd_stb, io_wr_stb, inta_stb  out  1 each  one-clk pulses.
- addr_q  out  16  address latched at the strobe.
- wdata_q  out  8  dout latched at a write strobe.
- timeout_stb  out  1  one-clk pulse when the ack wait expires.

Behaviour:
- Reset: wait_n=1; all strobes and timeout_stb 0; addr_q=0, wdata_q=0; FSM in IDLE; counters 0. Reset mid-cycle aborts any wait; wait_n is 1 from the clock after rst is sampled.
- Qualifiers (combinational, decoded from the inputs):
  - MR = !mreq_n & !rd_n & rfsh_n
  - OF = MR & !m1_n
  - MW = !mreq_n & !wr_n
  - IR = !iorq_n & !rd_n & m1_n
  - IW = !iorq_n & !wr_n
  - IA = !iorq_n & !m1_n
- Strobes: each strobe pulses for exactly one clk on the rising edge of its qualifier, tracked against a registered previous value. Strobes are independent of clk_enable and have a 1-clk latency after the qualifier.
  - mem_rd_stb fires on OF as well as plain MR; opfetch_stb additionally fires on OF.
  - Refresh cycles (rfsh_n=0) produce no strobe.
- Latching: addr_q <= A on any strobe. wdata_q <= dout on mem_wr_stb or io_wr_stb. Both hold until the next strobe.
- FSM states: IDLE, FIXED, ACKWAIT, DONE.
  - IDLE: stays in IDLE for memory cycles. On an IR or IW rising edge:
    - io_slow=1 and io_ack=0: go to ACKWAIT, wait_n<=0.
    - io_slow=1 and io_ack=1: go to DONE, wait_n stays 1.
    - io_slow=0 and IO_WAIT_TICKS>0: go to FIXED, wait_n<=0, tick counter<=0.
    - otherwise: go to DONE.
  - FIXED: count clk_enable ticks. When the count reaches IO_WAIT_TICKS, wait_n<=1 and go to DONE.
  - ACKWAIT: count clk_enable ticks.
    - io_ack=1: wait_n<=1, go to DONE.
    - Count reaches ACK_TIMEOUT with io_ack=0: wait_n<=1, pulse timeout_stb, go to DONE.
    - io_ack and the timeout in the same clk: ack wins, no timeout_stb.
  - DONE: return to IDLE once iorq_n=1.
- Interrupt acknowledge (IA) never inserts waits; inta_stb only.
- Counter width: clog2(ACK_TIMEOUT+1). The counter saturates and never wraps.
- Memory cycles never touch wait_n.

Decomposition:
- Shared package holds:
  - FSM state encoding (2-bit localparams IDLE/FIXED/ACKWAIT/DONE).
  - Bus-cycle type codes (MR, OF, MW, IR, IW, IA) for reuse by the bus trace and debug blocks.
- One sub-module: z80_edge_pulse, a registered rising-edge detector instantiated once per qualifier.

Test Plan:
- Opcode fetch at A=16'h0038: m1_n, mreq_n and rd_n low → opfetch_stb=1 and mem_rd_stb=1 for one clk, addr_q=16'h0038, wait_n stays 1.
- Memory write of dout=8'hA5 to 16'h4000 → a single mem_wr_stb pulse, wdata_q=8'hA5; the following refresh with mreq_n low and rfsh_n low gives no strobe.
- IO_WAIT_TICKS=2, fast OUT (io_slow=0) to 16'h00FE, dout=8'h07 → io_wr_stb once; wait_n low for exactly 2 clk_enable ticks, then 1; wdata_q=8'h07.
- io_slow=1 IN from 16'hFFFD, io_ack raised after 3 ticks → wait_n low until the clk after ack, no timeout_stb, FSM back to IDLE after iorq_n rises.
- io_slow=1 with io_ack never asserted, ACK_TIMEOUT=15 → wait_n released after the 15th tick, a single timeout_stb pulse; ack and timeout in the same clk → no timeout_stb.
- rst asserted while in ACKWAIT → wait_n=1 next clk, all strobes 0, the next I/O cycle is handled normally; an interrupt acknowledge (m1_n low, iorq_n low) → inta_stb only, no wait.
